// File: rtl/demo_pkg.sv
// Shared definitions for the demo scene sequencer: effect bit positions,
// sequencer states, the timeline entry layout and the fade ceiling.
package demo_pkg;

  localparam int EFF_STAR   = 0;
  localparam int EFF_PLANE  = 1;
  localparam int EFF_SCROLL = 2;
  localparam int EFF_SCOPE  = 3;

  // Width of the per-scene hold duration, counted in frames.
  localparam int HOLD_W = 10;

  localparam logic [5:0] FADE_MAX = 6'd63;

  // Mask of the first scene, needed as a constant for the reset value.
  localparam logic [3:0] SCENE0_MASK = 4'b0011;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2
  } scene_state_t;

  typedef struct packed {
    logic [3:0]        mask;
    logic [HOLD_W-1:0] hold;
  } scene_entry_t;

endpackage

// File: rtl/demo_scene_rom.sv
// Fixed demo timeline: scene index to effect mask and hold length in frames.
module demo_scene_rom
  import demo_pkg::*;
#(
  parameter int N_SCENES = 8
) (
  input  logic [$clog2(N_SCENES)-1:0] i_addr,
  output scene_entry_t                o_entry
);

  // Table lookup; every entry past scene 2 uses the full effect set.
  always_comb begin
    o_entry.mask = 4'b1111;
    o_entry.hold = HOLD_W'(300);
    case (int'(i_addr))
      0: begin
        o_entry.mask = SCENE0_MASK;
        o_entry.hold = HOLD_W'(240);
      end
      1: begin
        o_entry.mask = 4'b0111;
        o_entry.hold = HOLD_W'(480);
      end
      2: begin
        o_entry.mask = 4'b1111;
        o_entry.hold = HOLD_W'(0);
      end
      default: begin
        o_entry.mask = 4'b1111;
        o_entry.hold = HOLD_W'(300);
      end
    endcase
  end

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-rate scene scheduler: walks the timeline fading each scene in,
// holding it, fading it out, and looping after the last entry.
module demo_scene_sequencer
  import demo_pkg::*;
#(
  parameter int N_SCENES  = 8,
  parameter int FADE_STEP = 4
) (
  input  logic                        clk48,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic                        pause,
  input  logic                        skip,
  output logic [$clog2(N_SCENES)-1:0] scene_idx,
  output logic [3:0]                  effect_en,
  output logic [5:0]                  fade,
  output logic                        scene_start,
  output logic [3:0]                  loop_count,
  output logic                        busy_fading
);

  localparam int              IW       = $clog2(N_SCENES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_SCENES - 1);
  localparam logic [6:0]      STEP7    = 7'(FADE_STEP);

  scene_state_t      r_state;
  logic [IW-1:0]     r_scene_idx;
  logic [3:0]        r_effect_en;
  logic [5:0]        r_fade;
  logic              r_scene_start;
  logic [3:0]        r_loop_count;
  logic              r_busy;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_skip_pend;

  scene_state_t      w_state_nxt;
  logic [IW-1:0]     w_scene_idx_nxt;
  logic [3:0]        w_effect_en_nxt;
  logic [5:0]        w_fade_nxt;
  logic              w_scene_start_nxt;
  logic [3:0]        w_loop_count_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_skip_pend_nxt;

  logic              w_tick;
  logic              w_skip_eff;
  logic [IW-1:0]     w_idx_inc;
  logic [IW-1:0]     w_rom_addr;
  scene_entry_t      w_rom;
  logic [6:0]        w_fade_up7;
  logic [5:0]        w_fade_in;
  logic [5:0]        w_fade_out;

  assign w_tick     = frame_tick & ~pause;
  assign w_skip_eff = r_skip_pend | skip;
  assign w_idx_inc  = r_scene_idx + IW'(1);

  // While fading out the table is read for the following scene's mask;
  // otherwise it supplies the current scene's hold length.
  assign w_rom_addr = (r_state == FADE_OUT) ? w_idx_inc : r_scene_idx;

  // Saturating fade arithmetic on a 7-bit intermediate so no wrap occurs.
  assign w_fade_up7 = {1'b0, r_fade} + STEP7;
  assign w_fade_in  = (w_fade_up7 > 7'(FADE_MAX)) ? FADE_MAX : w_fade_up7[5:0];
  assign w_fade_out = ({1'b0, r_fade} < STEP7) ? 6'd0 : (r_fade - STEP7[5:0]);

  demo_scene_rom #(
    .N_SCENES (N_SCENES)
  ) u_rom (
    .i_addr  (w_rom_addr),
    .o_entry (w_rom)
  );

  // Next-state logic: nothing moves except on an unpaused frame tick,
  // apart from skip requests accumulating into the sticky pending flag.
  always_comb begin
    w_state_nxt       = r_state;
    w_scene_idx_nxt   = r_scene_idx;
    w_effect_en_nxt   = r_effect_en;
    w_fade_nxt        = r_fade;
    w_scene_start_nxt = 1'b0;
    w_loop_count_nxt  = r_loop_count;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_skip_pend_nxt   = w_skip_eff;
    if (w_tick) begin
      w_skip_pend_nxt = 1'b0;
      case (r_state)
        FADE_IN: begin
          if (w_skip_eff) begin
            w_state_nxt = FADE_OUT;
          end else begin
            w_fade_nxt = w_fade_in;
            if (w_fade_in == FADE_MAX) begin
              if (w_rom.hold == '0) begin
                w_state_nxt = FADE_OUT;
              end else begin
                w_state_nxt    = HOLD;
                w_hold_cnt_nxt = w_rom.hold;
              end
            end
          end
        end
        HOLD: begin
          if (w_skip_eff || (r_hold_cnt == HOLD_W'(1))) begin
            w_state_nxt = FADE_OUT;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
          end
        end
        FADE_OUT: begin
          w_fade_nxt = w_fade_out;
          if (w_fade_out == 6'd0) begin
            w_state_nxt       = FADE_IN;
            w_scene_idx_nxt   = w_idx_inc;
            w_effect_en_nxt   = w_rom.mask;
            w_scene_start_nxt = 1'b1;
            if (r_scene_idx == LAST_IDX) begin
              w_loop_count_nxt = r_loop_count + 4'd1;
            end
          end
        end
        default: begin
          w_state_nxt = FADE_IN;
        end
      endcase
    end
  end

  // State and output registers; reset drops straight back to scene 0, black.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FADE_IN;
      r_scene_idx   <= '0;
      r_effect_en   <= SCENE0_MASK;
      r_fade        <= 6'd0;
      r_scene_start <= 1'b0;
      r_loop_count  <= 4'd0;
      r_busy        <= 1'b1;
      r_hold_cnt    <= '0;
      r_skip_pend   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_scene_idx   <= w_scene_idx_nxt;
      r_effect_en   <= w_effect_en_nxt;
      r_fade        <= w_fade_nxt;
      r_scene_start <= w_scene_start_nxt;
      r_loop_count  <= w_loop_count_nxt;
      r_busy        <= (w_state_nxt != HOLD);
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_skip_pend   <= w_skip_pend_nxt;
    end
  end

  assign scene_idx   = r_scene_idx;
  assign effect_en   = r_effect_en;
  assign fade        = r_fade;
  assign scene_start = r_scene_start;
  assign loop_count  = r_loop_count;
  assign busy_fading = r_busy;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Self-checking bench for demo_scene_sequencer: directed timeline scenarios
// plus randomized tick/pause/skip traffic against a behavioural model.
module tb_demo_scene_sequencer;

  localparam int STEP = 4;

  logic       clk48 = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic       skip = 1'b0;
  logic [2:0] scene_idx;
  logic [3:0] effect_en;
  logic [5:0] fade;
  logic       scene_start;
  logic [3:0] loop_count;
  logic       busy_fading;

  int n_checks = 0;
  int n_pass   = 0;

  // Timeline as the demo describes it.
  int mask_tab [8] = '{3, 7, 15, 15, 15, 15, 15, 15};
  int hold_tab [8] = '{240, 480, 0, 300, 300, 300, 300, 300};

  // Model: phase 0 = fading in, 1 = holding, 2 = fading out.
  int m_phase, m_fade, m_hold, m_idx, m_loops, m_pend, m_start;

  demo_scene_sequencer #(
    .N_SCENES  (8),
    .FADE_STEP (STEP)
  ) dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .skip        (skip),
    .scene_idx   (scene_idx),
    .effect_en   (effect_en),
    .fade        (fade),
    .scene_start (scene_start),
    .loop_count  (loop_count),
    .busy_fading (busy_fading)
  );

  always #5 clk48 = ~clk48;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_phase = 0; m_fade = 0; m_hold = 0; m_idx = 0;
    m_loops = 0; m_pend = 0; m_start = 0;
  endtask

  task automatic model_step(input bit t, input bit p, input bit s);
    int pend_now;
    m_start  = 0;
    pend_now = (m_pend != 0 || s) ? 1 : 0;
    if (t && !p) begin
      m_pend = 0;
      if (m_phase == 0) begin
        if (pend_now != 0) m_phase = 2;
        else begin
          m_fade = (m_fade + STEP > 63) ? 63 : m_fade + STEP;
          if (m_fade == 63) begin
            if (hold_tab[m_idx] == 0) m_phase = 2;
            else begin m_phase = 1; m_hold = hold_tab[m_idx]; end
          end
        end
      end else if (m_phase == 1) begin
        if (pend_now != 0 || m_hold == 1) m_phase = 2;
        else m_hold = m_hold - 1;
      end else begin
        m_fade = (m_fade - STEP < 0) ? 0 : m_fade - STEP;
        if (m_fade == 0) begin
          m_idx = (m_idx + 1) % 8;
          if (m_idx == 0) m_loops = (m_loops + 1) % 16;
          m_start = 1;
          m_phase = 0;
        end
      end
    end else begin
      m_pend = pend_now;
    end
  endtask

  // One clock: inputs applied just after an edge, sampled 1 ns after the next.
  task automatic cycle(input bit t, input bit p, input bit s);
    frame_tick = t; pause = p; skip = s;
    @(posedge clk48); #1;
    model_step(t, p, s);
    frame_tick = 1'b0; pause = 1'b0; skip = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    model_reset();
    n_checks++; if (fade !== 6'd0) $display("[TB] FAIL reset_fade: got %0d expected 0", fade); else n_pass++;
    n_checks++; if (scene_idx !== 3'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", scene_idx); else n_pass++;
    n_checks++; if (effect_en !== 4'b0011) $display("[TB] FAIL reset_en: got %b expected 0011", effect_en); else n_pass++;
    n_checks++; if (scene_start !== 1'b0) $display("[TB] FAIL reset_start: got %b expected 0", scene_start); else n_pass++;
    n_checks++; if (loop_count !== 4'd0) $display("[TB] FAIL reset_loops: got %0d expected 0", loop_count); else n_pass++;
    n_checks++; if (busy_fading !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", busy_fading); else n_pass++;
    rst_n = 1'b1;
    cycle(0, 0, 0);
  endtask

  task automatic test_fade_in();
    int exp_f;
    for (int k = 1; k <= 16; k++) begin
      cycle(1, 0, 0);
      exp_f = (4 * k > 63) ? 63 : 4 * k;
      n_checks++; if (fade !== 6'(exp_f)) $display("[TB] FAIL fade_in_level: got %0d expected %0d", fade, exp_f); else n_pass++;
      cycle(0, 0, 0);
    end
    n_checks++; if (busy_fading !== 1'b0) $display("[TB] FAIL fade_in_to_hold: got %b expected 0", busy_fading); else n_pass++;
    n_checks++; if (effect_en !== 4'b0011) $display("[TB] FAIL fade_in_en: got %b expected 0011", effect_en); else n_pass++;
    n_checks++; if (scene_idx !== 3'd0) $display("[TB] FAIL fade_in_idx: got %0d expected 0", scene_idx); else n_pass++;
  endtask

  task automatic test_hold_and_advance();
    int exp_f;
    for (int k = 1; k <= 240; k++) begin
      cycle(1, 0, 0);
      if (k == 239) begin
        n_checks++; if (busy_fading !== 1'b0) $display("[TB] FAIL hold_len_early: got %b expected 0", busy_fading); else n_pass++;
      end
      cycle(0, 0, 0);
    end
    n_checks++; if (busy_fading !== 1'b1) $display("[TB] FAIL hold_len_end: got %b expected 1", busy_fading); else n_pass++;
    n_checks++; if (fade !== 6'd63) $display("[TB] FAIL hold_fade: got %0d expected 63", fade); else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      cycle(1, 0, 0);
      exp_f = (63 - 4 * k < 0) ? 0 : 63 - 4 * k;
      n_checks++; if (fade !== 6'(exp_f)) $display("[TB] FAIL fade_out_level: got %0d expected %0d", fade, exp_f); else n_pass++;
      if (k == 15) begin
        n_checks++; if (effect_en !== 4'b0011) $display("[TB] FAIL en_stable_fading: got %b expected 0011", effect_en); else n_pass++;
      end
      if (k < 16) cycle(0, 0, 0);
    end
    n_checks++; if (scene_idx !== 3'd1) $display("[TB] FAIL advance_idx: got %0d expected 1", scene_idx); else n_pass++;
    n_checks++; if (effect_en !== 4'b0111) $display("[TB] FAIL advance_en: got %b expected 0111", effect_en); else n_pass++;
    n_checks++; if (scene_start !== 1'b1) $display("[TB] FAIL start_pulse: got %b expected 1", scene_start); else n_pass++;
    cycle(0, 0, 0);
    n_checks++; if (scene_start !== 1'b0) $display("[TB] FAIL start_one_cycle: got %b expected 0", scene_start); else n_pass++;
  endtask

  task automatic test_skip_paused();
    repeat (16) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    repeat (3) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    cycle(0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      cycle(1, 1, 0);
      cycle(0, 1, 0);
      n_checks++; if (busy_fading !== 1'b0 || fade !== 6'd63) $display("[TB] FAIL paused_no_change: got busy=%b fade=%0d expected busy=0 fade=63", busy_fading, fade); else n_pass++;
    end
    cycle(1, 0, 0);
    n_checks++; if (busy_fading !== 1'b1) $display("[TB] FAIL skip_after_pause: got %b expected 1", busy_fading); else n_pass++;
    n_checks++; if (fade !== 6'd63) $display("[TB] FAIL skip_fade_kept: got %0d expected 63", fade); else n_pass++;
    cycle(0, 0, 0);
    repeat (16) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    n_checks++; if (scene_idx !== 3'd2) $display("[TB] FAIL skip_advance: got %0d expected 2", scene_idx); else n_pass++;
  endtask

  task automatic test_zero_hold();
    repeat (16) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    n_checks++; if (busy_fading !== 1'b1 || fade !== 6'd63) $display("[TB] FAIL zero_hold_state: got busy=%b fade=%0d expected busy=1 fade=63", busy_fading, fade); else n_pass++;
    cycle(1, 0, 0);
    n_checks++; if (fade !== 6'd59) $display("[TB] FAIL zero_hold_first_out: got %0d expected 59", fade); else n_pass++;
    cycle(0, 0, 0);
    repeat (15) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    n_checks++; if (scene_idx !== 3'd3) $display("[TB] FAIL zero_hold_advance: got %0d expected 3", scene_idx); else n_pass++;
  endtask

  task automatic test_skip_fade_in();
    repeat (5) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    n_checks++; if (fade !== 6'd20) $display("[TB] FAIL pre_skip_fade: got %0d expected 20", fade); else n_pass++;
    cycle(1, 0, 1);
    n_checks++; if (fade !== 6'd20 || busy_fading !== 1'b1) $display("[TB] FAIL skip_tick: got fade=%0d busy=%b expected fade=20 busy=1", fade, busy_fading); else n_pass++;
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    n_checks++; if (fade !== 6'd16) $display("[TB] FAIL skip_fading_out: got %0d expected 16", fade); else n_pass++;
    cycle(0, 0, 0);
    repeat (3) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    cycle(1, 0, 0);
    n_checks++; if (fade !== 6'd0 || scene_idx !== 3'd4 || scene_start !== 1'b1) $display("[TB] FAIL skip_scene_end: got fade=%0d idx=%0d start=%b expected fade=0 idx=4 start=1", fade, scene_idx, scene_start); else n_pass++;
    cycle(0, 0, 0);
  endtask

  task automatic test_random();
    bit t, p, s, prev_t;
    prev_t = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      t = prev_t ? 1'b0 : ($urandom_range(0, 2) != 0);
      p = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 39) == 0);
      prev_t = t;
      cycle(t, p, s);
      n_checks++; if (fade !== 6'(m_fade)) $display("[TB] FAIL rand_fade: got %0d expected %0d", fade, m_fade); else n_pass++;
      n_checks++; if (scene_idx !== 3'(m_idx)) $display("[TB] FAIL rand_idx: got %0d expected %0d", scene_idx, m_idx); else n_pass++;
      n_checks++; if (effect_en !== 4'(mask_tab[m_idx])) $display("[TB] FAIL rand_en: got %b expected %0d", effect_en, mask_tab[m_idx]); else n_pass++;
      n_checks++; if (scene_start !== 1'(m_start)) $display("[TB] FAIL rand_start: got %b expected %0d", scene_start, m_start); else n_pass++;
      n_checks++; if (busy_fading !== (m_phase != 1)) $display("[TB] FAIL rand_busy: got %b expected %0d", busy_fading, m_phase != 1); else n_pass++;
      n_checks++; if (loop_count !== 4'(m_loops)) $display("[TB] FAIL rand_loops: got %0d expected %0d", loop_count, m_loops); else n_pass++;
    end
    cycle(0, 0, 0);
  endtask

  task automatic test_loop_wrap();
    bit wrapped;
    int prev;
    wrapped = 1'b0;
    for (int n = 0; n < 20000 && !wrapped; n++) begin
      prev = m_loops;
      cycle(1, 0, m_phase == 1);
      n_checks++; if (loop_count !== 4'(m_loops) || fade !== 6'(m_fade)) $display("[TB] FAIL loop_track: got loops=%0d fade=%0d expected loops=%0d fade=%0d", loop_count, fade, m_loops, m_fade); else n_pass++;
      if (prev == 15 && m_loops == 0) wrapped = 1'b1;
      cycle(0, 0, 0);
    end
    n_checks++; if (!wrapped || loop_count !== 4'd0 || scene_idx !== 3'd0) $display("[TB] FAIL loop_wrap: got wrapped=%b loops=%0d idx=%0d expected wrapped=1 loops=0 idx=0", wrapped, loop_count, scene_idx); else n_pass++;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      cycle(1, 0, m_phase == 1);
      cycle(0, 0, 0);
      if (m_loops == 1 && m_idx == 1 && m_phase == 2 && m_fade == 31) found = 1'b1;
    end
    n_checks++; if (!found || fade !== 6'd31 || loop_count !== 4'd1) $display("[TB] FAIL reach_fade31: got found=%b fade=%0d loops=%0d expected found=1 fade=31 loops=1", found, fade, loop_count); else n_pass++;
    cycle(0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (fade !== 6'd0 || scene_idx !== 3'd0 || loop_count !== 4'd0) $display("[TB] FAIL async_reset: got fade=%0d idx=%0d loops=%0d expected 0 0 0", fade, scene_idx, loop_count); else n_pass++;
    n_checks++; if (effect_en !== 4'b0011 || busy_fading !== 1'b1) $display("[TB] FAIL async_reset_en: got en=%b busy=%b expected 0011 1", effect_en, busy_fading); else n_pass++;
    @(posedge clk48); #1;
    rst_n = 1'b1;
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    n_checks++; if (fade !== 6'd4 || busy_fading !== 1'b1) $display("[TB] FAIL skip_cleared_by_reset: got fade=%0d busy=%b expected 4 1", fade, busy_fading); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_hold_and_advance();
    test_skip_paused();
    test_zero_hold();
    test_skip_fade_in();
    test_random();
    test_loop_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demo_scene_sequencer.md
Name: demo_scene_sequencer

Overview:
- Frame-rate scheduler that sequences the demo's effect datapath (starfield, 3D plane, sine scroller, oscilloscope) through a fixed timeline of scenes.
- Each scene fades in, holds for a programmed number of frames, then fades out; the next scene follows, and the timeline loops after the last scene.
- Sits beside the VGA timing/effect core. Consumes a one-cycle new-frame strobe and drives effect-enable bits plus a 6-bit fade level, which the colour mux multiplies or gates before dithering.

Parameters:
- N_SCENES, 8, number of timeline entries; must be a power of two, 2..16.
- FADE_STEP, 4, fade level change per frame tick, 1..63.
- HOLD_W, 10, width of per-scene hold duration in frames.

Ports:
- clk48  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse per video frame; never high two consecutive cycles.
- pause  input  1  level; while high, frame_tick is ignored.
- skip  input  1  one-cycle request to end the current scene early.
- scene_idx  output  $clog2(N_SCENES)  current scene index.
- effect_en  output  4  bit0 starfield, bit1 plane, bit2 scroller, bit3 oscilloscope.
- fade  output  6  brightness level, 0 = black, 63 = full.
- scene_start  output  1  one-cycle pulse when a new scene begins.
- loop_count  output  4  completed timeline passes; wraps 15→0.
- busy_fading  output  1  high in FADE_IN or FADE_OUT.

Behaviour:
- Reset (async assert, sync release): state=FADE_IN, scene_idx=0, fade=0, effect_en=rom[0].mask, hold_cnt=0, skip_pend=0, loop_count=0, scene_start=0.
- All outputs are registered. A "tick" is frame_tick & ~pause. State and outputs update the cycle after the tick; there is no other activity.
- skip sets skip_pend, which stays sticky until consumed.
  - skip coincident with a tick is seen by that tick.
  - skip while paused stays pending.
- FADE_IN, on tick:
  - If skip_pend: go to FADE_OUT, fade unchanged, clear skip_pend.
  - Else fade <= min(fade+FADE_STEP, 63).
  - If the new fade is 63 and rom.hold==0: go to FADE_OUT.
  - If the new fade is 63 and rom.hold!=0: go to HOLD, hold_cnt <= rom.hold.
- HOLD, on tick:
  - If skip_pend or hold_cnt==1: go to FADE_OUT, clear skip_pend.
  - Else hold_cnt <= hold_cnt-1.
  - HOLD therefore lasts exactly rom.hold ticks.
- FADE_OUT, on tick:
  - fade <= max(fade-FADE_STEP, 0); skip_pend is cleared with no effect.
  - If the new fade is 0:
    - scene_idx <= scene_idx+1 (mod N_SCENES).
    - effect_en <= rom[next].mask.
    - State goes to FADE_IN.
    - scene_start pulses for one cycle.
    - If wrapping from N_SCENES-1 to 0, loop_count increments.
- With FADE_STEP=4, both fade-in (0→63) and fade-out (63→0) take 16 ticks.
- effect_en changes only at the scene boundary, so it is never altered while fade>0.
- Saturation arithmetic uses 7-bit intermediates; no wrap-around of fade.
- Reset mid-fade or mid-hold returns to the reset state immediately; no pending skip survives.

Decomposition:
- Shared package demo_pkg:
  - Effect bit indices: EFF_STAR=0, EFF_PLANE=1, EFF_SCROLL=2, EFF_SCOPE=3.
  - Enum for state (FADE_IN, HOLD, FADE_OUT).
  - Scene entry struct (mask[3:0], hold[HOLD_W-1:0]).
  - FADE_MAX=63.
- Sub-module demo_scene_rom: combinational table, addr → {mask, hold}. Defaults:
  - 0: 4'b0011, 240.
  - 1: 4'b0111, 480.
  - 2: 4'b1111, 0.
  - 3–7: 4'b1111, 300.

Test Plan:
- Reset, then 16 ticks → fade goes 0,4,…,60,63; state=HOLD after tick 16; effect_en=4'b0011, scene_idx=0.
- Continue 240 ticks → FADE_OUT entered after tick 256; 16 more ticks → fade=0, scene_idx=1, effect_en=4'b0111, scene_start high exactly one cycle.
- Scene 2 (hold=0): after fade-in reaches 63, the very next state is FADE_OUT; zero HOLD ticks.
- skip pulse during HOLD of scene 1 with pause high for 10 ticks → no change while paused; the first unpaused tick enters FADE_OUT; fade unchanged that tick.
- skip coincident with a FADE_IN tick at fade=20 → fade stays 20, state=FADE_OUT; 5 ticks later fade=0 and the scene advances.
- Run the full timeline 16 times → loop_count wraps 15→0. Assert rst_n mid-fade-out at fade=31 → fade=0, scene_idx=0, loop_count=0 asynchronously.
